// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc;      // operand A shifts out the bottom, partial sum shifts in the top
   logic [WIDTH-1:0] opb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dadd;
   logic [WIDTH-1:0] acc_nx;
   logic             last;
   logic             accept;

   assign dadd   = {1'b0, acc[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + (DIGIT+1)'(carry);
   assign last   = (cnt == CW'(N - 1));
   assign accept = start && (state_q != RUN);
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);

   generate
      if (N > 1) begin : g_multi
         assign acc_nx = {dadd[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
      end else begin : g_single
         assign acc_nx = dadd[DIGIT-1:0];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: state_d = start ? RUN : IDLE;
         RUN:        state_d = last ? DONE : RUN;
         default:    state_d = IDLE;
      endcase
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic amsb, bmsb;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc     <= '0;
         opb     <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         amsb    <= 1'b0;
         bmsb    <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            acc   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            amsb  <= a[WIDTH-1];
            bmsb  <= b[WIDTH-1];
`endif
         end else if (state_q == RUN) begin
            acc   <= acc_nx;
            opb   <= opb >> DIGIT;
            carry <= dadd[DIGIT];
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum  <= acc_nx;
               cout <= dadd[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
               ovf  <= (amsb == bmsb) && (acc_nx[WIDTH-1] != amsb);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (1/1, 8/1, 8/4) share clock and reset.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       s1, s8, s4;
   logic [0:0] a1, b1;
   logic [7:0] a8, b8, a4, b4;
   logic       c1, c8, c4;
   logic       busy1, done1, cout1, busy8, done8, cout8, busy4, done4, cout4;
   logic [0:0] sum1;
   logic [7:0] sum8, sum4;
   logic       ovf1, ovf8, ovf4;

   int nchecks = 0;
   int nerr    = 0;

   logic [9:0] q1[$], q8[$], q4[$];   // {ovf, 9-bit {cout,sum}}

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
      .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .cin(c1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(c8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .cin(c4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf4)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf1 = 1'b0;
   assign ovf8 = 1'b0;
   assign ovf4 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive a start request (caller is at a negedge) and push the model result.
   task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [1:0] r1;
      logic [8:0] r;
      if (sel == 0) begin
         a1 = a[0]; b1 = b[0]; c1 = c; s1 = 1'b1;
         r1 = {1'b0, a[0]} + {1'b0, b[0]} + {1'b0, c};
         q1.push_back({(a[0] == b[0]) && (r1[0] != a[0]), 7'b0, r1});
      end else begin
         r = {1'b0, a} + {1'b0, b} + {8'b0, c};
         if (sel == 1) begin
            a8 = a; b8 = b; c8 = c; s8 = 1'b1;
            q8.push_back({(a[7] == b[7]) && (r[7] != a[7]), r});
         end else begin
            a4 = a; b4 = b; c4 = c; s4 = 1'b1;
            q4.push_back({(a[7] == b[7]) && (r[7] != a[7]), r});
         end
      end
   endtask

   // Count edges from the start edge until done is seen; optionally disturb mid-run.
   task automatic wait_done(input int sel, input bit disturb, output int cyc, output int bsy);
      logic d, bz;
      cyc = 0;
      bsy = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cyc++;
         case (sel)
            0: s1 = 1'b0;
            1: s8 = 1'b0;
            default: s4 = 1'b0;
         endcase
         if (disturb && sel == 1 && cyc == 3) begin
            s8 = 1'b1; a8 = 8'hAA; b8 = 8'hBB; c8 = 1'b0;
         end
         d  = (sel == 0) ? done1 : (sel == 1) ? done8 : done4;
         bz = (sel == 0) ? busy1 : (sel == 1) ? busy8 : busy4;
         if (d) return;
         if (bz) bsy++;
      end
      check("timeout", 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      if (!rst && done1) begin
         if (q1.size() == 0) check("w1_spurious_done", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            check("w1_sum", {30'd0, cout1, sum1}, {22'd0, e[9:0]} & 32'h3);
`ifdef SERIAL_ADDER_OVF_EN
            check("w1_ovf", {31'd0, ovf1}, {31'd0, e[9]});
`endif
         end
      end
      if (!rst && done8) begin
         if (q8.size() == 0) check("d1_spurious_done", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            check("d1_sum", {23'd0, cout8, sum8}, {23'd0, e[8:0]});
`ifdef SERIAL_ADDER_OVF_EN
            check("d1_ovf", {31'd0, ovf8}, {31'd0, e[9]});
`endif
         end
      end
      if (!rst && done4) begin
         if (q4.size() == 0) check("d4_spurious_done", 32'd1, 32'd0);
         else begin
            e = q4.pop_front();
            check("d4_sum", {23'd0, cout4, sum4}, {23'd0, e[8:0]});
`ifdef SERIAL_ADDER_OVF_EN
            check("d4_ovf", {31'd0, ovf4}, {31'd0, e[9]});
`endif
         end
      end
   end

   initial begin
      int cyc, bsy, dcnt;
      logic [2:0] v;
      rst = 1'b1;
      s1 = 0; s8 = 0; s4 = 0; a1 = 0; b1 = 0; c1 = 0;
      a8 = 0; b8 = 0; c8 = 0; a4 = 0; b4 = 0; c4 = 0;
      repeat (3) @(negedge clk);
      check("rst_d1_outs", {20'd0, busy8, done8, cout8, sum8, ovf8}, 32'd0);
      check("rst_d4_outs", {20'd0, busy4, done4, cout4, sum4, ovf4}, 32'd0);
      check("rst_w1_outs", {27'd0, busy1, done1, cout1, sum1, ovf1}, 32'd0);
      rst = 1'b0;

      // full-adder truth table
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         @(negedge clk);
         drive(0, {7'd0, v[2]}, {7'd0, v[1]}, v[0]);
         wait_done(0, 1'b0, cyc, bsy);
         check("w1_latency", cyc, 32'd2);
         check("w1_busy_cycles", bsy, 32'd1);
      end

      @(negedge clk);
      drive(1, 8'hFF, 8'h01, 1'b0);
      wait_done(1, 1'b0, cyc, bsy);
      check("d1_latency", cyc, 32'd9);
      check("d1_busy_cycles", bsy, 32'd8);

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(1, 8'($urandom), 8'($urandom), 1'($urandom));
         wait_done(1, 1'b0, cyc, bsy);
         check("d1_rand_latency", cyc, 32'd9);
      end

      // back-to-back: second start issued during the DONE cycle
      @(negedge clk);
      drive(2, 8'h3C, 8'hC3, 1'b1);
      wait_done(2, 1'b0, cyc, bsy);
      check("d4_latency", cyc, 32'd3);
      check("d4_busy_cycles", bsy, 32'd2);
      drive(2, 8'h01, 8'h02, 1'b0);
      wait_done(2, 1'b0, cyc, bsy);
      check("d4_b2b_latency", cyc, 32'd3);
      @(negedge clk);
      check("d4_idle_after", {31'd0, busy4 | done4}, 32'd0);

      // start and operands changed mid-run are ignored
      @(negedge clk);
      drive(1, 8'h12, 8'h34, 1'b1);
      wait_done(1, 1'b1, cyc, bsy);
      check("d1_disturb_latency", cyc, 32'd9);
      @(negedge clk);
      check("d1_single_done", {31'd0, done8 | busy8}, 32'd0);

`ifdef SERIAL_ADDER_OVF_EN
      @(negedge clk);
      drive(1, 8'h7F, 8'h01, 1'b0);
      wait_done(1, 1'b0, cyc, bsy);
      check("ovf_pos", {31'd0, ovf8}, 32'd1);
      @(negedge clk);
      drive(1, 8'hFF, 8'h01, 1'b0);
      wait_done(1, 1'b0, cyc, bsy);
      check("ovf_neg", {31'd0, ovf8}, 32'd0);
`endif

      // reset on the 4th RUN cycle aborts without a done pulse
      @(negedge clk);
      drive(1, 8'h55, 8'h66, 1'b0);
      @(negedge clk);
      s8 = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", {31'd0, busy8}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q8.delete();
      check("abort_outs", {20'd0, busy8, done8, cout8, sum8, ovf8}, 32'd0);
      dcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) dcnt++;
      end
      check("abort_no_done", dcnt, 32'd0);

      repeat (2) @(negedge clk);
      check("sb_empty", q1.size() + q8.size() + q4.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
